// File: rtl/i2s_dac_out.sv
// i2s_dac_out: serialises a mono sample stream onto both I2S slots.
// Ports: Clock/Reset, WaveIn/WaveValid/WaveReady in, BitClk/WordSel/SerData/Underrun out.
module i2s_dac_out #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int CLK_DIV      = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [SAMPLE_WIDTH-1:0] WaveIn,
  input  logic                    WaveValid,
  output logic                    WaveReady,
  output logic                    BitClk,
  output logic                    WordSel,
  output logic                    SerData,
  output logic                    Underrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(2 * SLOT_WIDTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(2 * SLOT_WIDTH - 1);
  localparam logic [IW-1:0] WS_LAST  = IW'(2 * SLOT_WIDTH - 2);
  localparam logic [IW-1:0] SLOT     = IW'(SLOT_WIDTH);
  localparam logic [IW-1:0] WS_FIRST = IW'(SLOT_WIDTH - 1);

  logic [DW-1:0]           r_div;
  logic                    r_bclk;
  logic [IW-1:0]           r_idx;
  logic                    r_ws;
  logic                    r_sd;
  logic                    r_ur;
  logic [SAMPLE_WIDTH-1:0] r_active;
  logic [SAMPLE_WIDTH-1:0] r_pend;
  logic                    r_full;
  logic                    r_ready;

  logic                    w_fall;
  logic [IW-1:0]           w_idx_nx;
  logic                    w_frame;
  logic                    w_load;
  logic                    w_accept;
  logic [SAMPLE_WIDTH-1:0] w_active_nx;
  logic [IW-1:0]           w_k;
  logic                    w_ws;
  logic                    w_sd;

  always_comb begin
    w_fall      = (r_div == DIV_LAST) && r_bclk;
    w_idx_nx    = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    w_frame     = w_fall && (w_idx_nx == '0);
    w_load      = w_frame && r_full;
    w_accept    = WaveValid && r_ready;
    // Bit 0 of a new frame already uses the freshly loaded sample.
    w_active_nx = w_load ? r_pend : r_active;
    w_k         = (w_idx_nx >= SLOT) ? w_idx_nx - SLOT : w_idx_nx;
    // Word select leads its slot by one bit.
    w_ws        = (w_idx_nx >= WS_FIRST) && (w_idx_nx <= WS_LAST);
    w_sd        = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (w_k == IW'(i)) w_sd = w_active_nx[SAMPLE_WIDTH-1-i];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_div    <= '0;
      r_bclk   <= 1'b0;
      r_idx    <= IDX_LAST;
      r_ws     <= 1'b0;
      r_sd     <= 1'b0;
      r_ur     <= 1'b0;
      r_active <= '0;
      r_pend   <= '0;
      r_full   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_ur <= w_frame && !r_full;
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_idx    <= w_idx_nx;
        r_ws     <= w_ws;
        r_sd     <= w_sd;
        r_active <= w_active_nx;
      end
      // Load and accept are exclusive: accept needs an empty register.
      if (w_load) begin
        r_full  <= 1'b0;
        r_ready <= 1'b1;
      end else if (w_accept) begin
        r_pend  <= WaveIn;
        r_full  <= 1'b1;
        r_ready <= 1'b0;
      end
    end
  end

  assign WaveReady = r_ready;
  assign BitClk    = r_bclk;
  assign WordSel   = r_ws;
  assign SerData   = r_sd;
  assign Underrun  = r_ur;

endmodule
